// File: rtl/mitll_or2t_sched_if.sv
// mitll_or2t_sched_if: requester, cell-strobe and status signals of the OR2 cell scheduler
interface mitll_or2t_sched_if #(parameter int NREQ = 4);
    logic [NREQ-1:0] req, op_a, op_b, gnt, done;
    logic result, busy, a_pls, b_pls, clk_pls, out_pls, err_spur, err_mis;
    modport master (
        output req, op_a, op_b, out_pls,
        input  gnt, done, result, busy, a_pls, b_pls, clk_pls, err_spur, err_mis
    );
    modport slave (
        input  req, op_a, op_b, out_pls,
        output gnt, done, result, busy, a_pls, b_pls, clk_pls, err_spur, err_mis
    );
endinterface

// File: rtl/mitll_or2t_sched.sv
// mitll_or2t_sched: round-robin scheduler sharing one clocked OR2 cell among NREQ requesters
module mitll_or2t_sched #(
    parameter int NREQ      = 4,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int OUT_WIN   = 3
) (
    input logic clk,
    input logic rst,
    mitll_or2t_sched_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [2:0] {IDLE, DRIVE, SETUP, CLOCK, CAPTURE, DONE, HOLD} state_t;
    state_t state;
    logic [IW-1:0] ptr, w, win, idx;
    logic [7:0] cnt;
    logic la, lb, cap;
    // highest offset first so the requester nearest after ptr overwrites the rest
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (bus.req[idx]) win = idx;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= IW'(NREQ - 1);
            w            <= '0;
            cnt          <= '0;
            la           <= 1'b0;
            lb           <= 1'b0;
            cap          <= 1'b0;
            bus.gnt      <= '0;
            bus.done     <= '0;
            bus.result   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.a_pls    <= 1'b0;
            bus.b_pls    <= 1'b0;
            bus.clk_pls  <= 1'b0;
            bus.err_spur <= 1'b0;
            bus.err_mis  <= 1'b0;
        end else begin
            bus.a_pls   <= 1'b0;
            bus.b_pls   <= 1'b0;
            bus.clk_pls <= 1'b0;
            bus.done    <= '0;
            bus.result  <= 1'b0;
            cnt         <= cnt - 8'd1;
            if (bus.out_pls && state != CAPTURE) bus.err_spur <= 1'b1;
            case (state)
                IDLE: if (|bus.req) begin
                    state     <= DRIVE;
                    w         <= win;
                    la        <= bus.op_a[win];
                    lb        <= bus.op_b[win];
                    bus.gnt   <= NREQ'(1) << win;
                    bus.a_pls <= bus.op_a[win];
                    bus.b_pls <= bus.op_b[win];
                    bus.busy  <= 1'b1;
                end
                DRIVE: begin
                    state <= SETUP;
                    cnt   <= 8'(SETUP_CYC - 1);
                end
                SETUP: if (cnt == '0) begin
                    state       <= CLOCK;
                    bus.clk_pls <= 1'b1;
                end
                CLOCK: begin
                    state <= CAPTURE;
                    cap   <= 1'b0;
                    cnt   <= 8'(OUT_WIN - 1);
                end
                CAPTURE: begin
                    cap <= cap | bus.out_pls;
                    if (cnt == '0) begin
                        state      <= DONE;
                        bus.done   <= bus.gnt;
                        bus.result <= cap | bus.out_pls;
                        if ((cap | bus.out_pls) != (la | lb)) bus.err_mis <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= HOLD;
                    ptr     <= w;
                    bus.gnt <= '0;
                    cnt     <= 8'(HOLD_CYC - 1);
                end
                HOLD: if (cnt == '0) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mitll_or2t_sched.md
# mitll_or2t_sched

Synchronous controller that shares one clocked OR2 cell (mitll_or2t) among NREQ requesters. It round-robin arbitrates requests and drives the cell's a, b and clk pulse inputs as one-cycle strobes with enforced setup and hold spacing. It captures the cell's out pulse inside a fixed window, returns the result to the granted requester, and self-checks the result against the expected OR. It sits between test/emulation control logic and the cell model, or its pulse-interface wrapper.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- SETUP_CYC, 2, idle cycles between a/b strobe and clk strobe (>=1)
- HOLD_CYC, 1, idle cycles after DONE before the next a/b strobe (>=1)
- OUT_WIN, 3, cycles after clk strobe in which out_pls is accepted (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  request per requester, held high until its done
- op_a  in  NREQ  per-requester value to pulse on cell input a
- op_b  in  NREQ  per-requester value to pulse on cell input b
- gnt  out  NREQ  one-hot grant, held from DRIVE through DONE
- done  out  NREQ  one-hot, one-cycle completion strobe
- result  out  1  captured cell output, valid only while done is nonzero
- busy  out  1  high in every state except IDLE
- a_pls  out  1  one-cycle strobe to cell input a
- b_pls  out  1  one-cycle strobe to cell input b
- clk_pls  out  1  one-cycle strobe to cell clock input
- out_pls  in  1  strobe from cell output
- err_spur  out  1  sticky: out_pls seen outside a capture window
- err_mis  out  1  sticky: result != (op_a | op_b) of the latched op

## Operation
- Reset (asynchronous): state IDLE; all outputs 0; RR pointer set so requester 0 has top priority; op latches and counters cleared.
- FSM states: IDLE, DRIVE, SETUP, CLOCK, CAPTURE, DONE, HOLD.
- IDLE: if any req bit is set, choose a winner by round robin, starting from (last winner + 1) mod NREQ. Latch the winner's index, op_a and op_b, then go to DRIVE. Otherwise stay in IDLE.
- DRIVE (1 cycle): gnt[w]=1; a_pls=latched op_a; b_pls=latched op_b. Go to SETUP.
- SETUP (SETUP_CYC cycles): all strobes low. Go to CLOCK.
- CLOCK (1 cycle): clk_pls=1; clear the capture flag. Go to CAPTURE.
- CAPTURE (OUT_WIN cycles): out_pls sets the capture flag. Multiple pulses in the window count as one. Go to DONE.
- DONE (1 cycle): done[w]=1; result=capture flag; err_mis set if result != (op_a|op_b). Update the RR pointer to w. Go to HOLD.
- HOLD (HOLD_CYC cycles): all strobes low. Go to IDLE.
- An out_pls in any state other than CAPTURE sets err_spur. An out_pls in the CLOCK cycle itself counts as spurious.
- Requests with op_a=op_b=0 still run the full sequence, with clk_pls and an expected result of 0.
- If req[w] drops while granted, it is ignored: the op completes and done[w] is still issued. Changes to op_a/op_b after latching are ignored.
- Reset mid-operation aborts immediately: no done is issued, and the request is re-arbitrated after reset if still held.
- err_spur and err_mis clear only on rst.

## Timing
- All outputs are registered.
- Let cycle 0 be IDLE with req sampled. DRIVE is cycle 1, SETUP is cycles 2..1+S, CLOCK is cycle 2+S, CAPTURE is cycles 3+S..2+S+W, DONE is cycle 3+S+W, and HOLD is the next H cycles.
- Defaults (S=2, W=3, H=1): a/b strobe at cycle 1, clk_pls at 4, capture window 5..7, done at 8, HOLD at 9, IDLE at 10, next DRIVE at 11.
- Throughput is one op per 4+S+W+H cycles (10 at default) under continuous requests.
- busy rises in the cycle after the IDLE req sample and falls on entry to IDLE.
- gnt is asserted in exactly the cycles DRIVE..DONE and is never active for two requesters at once.

## Test plan
- Reset, then req=0001 with op_a[0]=1: gnt=0001 in cycles 1..8, a_pls at cycle 1, clk_pls at 4. With out_pls at 5, done=0001 and result=1 at 8; err flags stay 0.
- req=0001 with op_a=op_b=0 and no out_pls: clk_pls at 4, done at 8 with result=0, err_mis=0. Then repeat with op_a=1 and no out_pls: result=0 and err_mis=1.
- All four req high continuously: grants go 0,1,2,3,0 with successive DRIVE cycles 10 cycles apart; each done matches its gnt.
- Inject out_pls at cycle 4 (CLOCK) and at cycle 9 (HOLD): err_spur=1, result unaffected. err_spur stays set until rst.
- Assert rst in cycle 5 of an op: all outputs 0 at once and no done. After release, the still-held req restarts at DRIVE one cycle after the IDLE sample.
- Drop req[2] during its SETUP: the op completes, and done=0100 at the DONE cycle.
